// File: rtl/alu_pkg.sv
// alu_pkg -- shared types for the ALU issue stage.
//   DATA_W      : operand / result width
//   opcode_e    : opcodes the ALU implements (anything else is flagged as an error)
//   op_entry_t  : one queued operation {a, b, opcode, fwd}
//   is_legal_op : true for the three implemented opcodes
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_SUB = 3'b001,
    OP_GT  = 3'b010,
    OP_LT  = 3'b011
  } opcode_e;

  // The opcode is kept as raw bits so illegal codes travel through unchanged
  // and can be reported on out_opcode.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        opcode;
    logic              fwd;
  } op_entry_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_GT) || (op == OP_LT);
  endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// alu_op_fifo -- operation queue feeding the ALU.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full, even if popping)
//   push_data  : operation to enqueue
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest entry, all zero when empty
//   full/empty : queue status
//   occupancy  : number of entries held (0..DEPTH)
module alu_op_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  op_entry_t                push_data,
  input  logic                     pop,
  output op_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] OCC_ONE  = (PTR_W+1)'(1);

  op_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (occupancy == OCC_FULL);
  assign empty   = (occupancy == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only ever read after it was written,
  // so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage -- queues ALU operations, presents the head to an external
// combinational ALU and registers its result with a valid/ready handshake.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   in_valid/in_ready, in_a/b/opcode  : upstream operation handshake
//   in_fwd                            : use previous result as operand A
//   alu_a/alu_b/alu_opcode            : head operation to the ALU (zero when empty)
//   alu_result                        : ALU result for the head operation
//   out_valid/out_ready               : downstream handshake
//   out_result/out_opcode/out_err     : registered result, its opcode, illegal-opcode flag
//   occupancy                         : entries in the operation queue
// Build option: define ALU_ISSUE_FWD_EN to enable result forwarding via in_fwd;
// without it in_fwd is ignored.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_a,
  input  logic [31:0]                 in_b,
  input  logic [2:0]                  in_opcode,
  input  logic                        in_fwd,
  output logic [31:0]                 alu_a,
  output logic [31:0]                 alu_b,
  output logic [2:0]                  alu_opcode,
  input  logic [31:0]                 alu_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_result,
  output logic [2:0]                  out_opcode,
  output logic                        out_err,
  output logic [$clog2(FIFO_DEPTH):0] occupancy
);

  typedef enum logic {OUT_EMPTY, OUT_HOLD} out_state_e;

  out_state_e out_state;
  op_entry_t  push_entry;
  op_entry_t  head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  assign in_ready = !fifo_full;

  // Capture whenever there is work and the output register is free or draining.
  assign pop = !fifo_empty && ((out_state == OUT_EMPTY) || out_ready);

  alu_op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  assign alu_b      = head.b;
  assign alu_opcode = head.opcode;

`ifdef ALU_ISSUE_FWD_EN
  logic [DATA_W-1:0] last_result;

  always_comb begin
    push_entry = '{a: in_a, b: in_b, opcode: in_opcode, fwd: in_fwd};
  end

  // NOTE: default assignment first so every path drives alu_a and no latch forms.
  always_comb begin
    alu_a = head.a;
    if (head.fwd) alu_a = last_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_result <= '0;
    else if (pop) last_result <= alu_result;
  end
`else
  logic unused_fwd;

  always_comb begin
    push_entry = '{a: in_a, b: in_b, opcode: in_opcode, fwd: 1'b0};
  end

  assign alu_a      = head.a;
  assign unused_fwd = in_fwd ^ head.fwd;
`endif

  // Output register: EMPTY <-> HOLD. A capture overrides a same-edge drain so
  // back-to-back results stream at one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state  <= OUT_EMPTY;
      out_result <= '0;
      out_opcode <= '0;
      out_err    <= 1'b0;
    end else if (pop) begin
      out_state  <= OUT_HOLD;
      out_result <= alu_result;
      out_opcode <= head.opcode;
      out_err    <= !is_legal_op(head.opcode);
    end else if ((out_state == OUT_HOLD) && out_ready) begin
      out_state  <= OUT_EMPTY;
    end
  end

  assign out_valid = (out_state == OUT_HOLD);

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage -- self-checking bench for alu_issue_stage.
// Emulates the external ALU and keeps a transaction-level reference model
// (a queue of pending ops plus one held result) updated once per clock.
// Honours ALU_ISSUE_FWD_EN the same way the design does.
module tb_alu_issue_stage;

  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH) + 1;
`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [2:0]       in_opcode;
  logic             in_fwd;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_opcode;
  logic [31:0]      alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [2:0]       out_opcode;
  logic             out_err;
  logic [OCC_W-1:0] occupancy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_issue_stage #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_opcode  (in_opcode),
    .in_fwd     (in_fwd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_opcode (out_opcode),
    .out_err    (out_err),
    .occupancy  (occupancy)
  );

  // External ALU behaviour: SUB, unsigned GT, unsigned LT, zero otherwise.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'b001:  return a - b;
      3'b010:  return (a > b) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_opcode, alu_a, alu_b);

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        fwd;
  } tb_op_t;

  tb_op_t      mq[$];
  bit          m_valid;
  logic [31:0] m_result;
  logic [2:0]  m_op;
  bit          m_err;
  logic [31:0] m_last;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid  = 1'b0;
    m_result = '0;
    m_op     = '0;
    m_err    = 1'b0;
    m_last   = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"},  32'(out_valid),  32'(m_valid));
    check({tag, ".out_result"}, out_result,      m_result);
    check({tag, ".out_opcode"}, 32'(out_opcode), 32'(m_op));
    check({tag, ".out_err"},    32'(out_err),    32'(m_err));
    check({tag, ".occupancy"},  32'(occupancy),  32'(mq.size()));
    check({tag, ".in_ready"},   32'(in_ready),   32'(mq.size() < DEPTH));
  endtask

  // One clock: drive inputs, check the ALU-facing head, advance the model on
  // the edge, then check the registered outputs. Starts and ends 1 time unit
  // after a rising edge.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic fwd, input logic ordy,
                       output bit accepted);
    tb_op_t      hd;
    logic [31:0] exp_a;
    bit          push;
    bit          pop;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
    in_fwd    = fwd;
    out_ready = ordy;
    #1;
    push = v && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && (!m_valid || ordy);
    if (mq.size() > 0) begin
      hd    = mq[0];
      exp_a = (FWD_ON && hd.fwd) ? m_last : hd.a;
    end else begin
      hd    = '{a: '0, b: '0, op: '0, fwd: 1'b0};
      exp_a = '0;
    end
    check("alu_a",      alu_a,            exp_a);
    check("alu_b",      alu_b,            hd.b);
    check("alu_opcode", 32'(alu_opcode),  32'(hd.op));
    check("in_ready",   32'(in_ready),    32'(mq.size() < DEPTH));
    @(posedge clk);
    if (pop) begin
      m_valid  = 1'b1;
      m_result = alu_ref(hd.op, exp_a, hd.b);
      m_op     = hd.op;
      m_err    = !(hd.op inside {3'b001, 3'b010, 3'b011});
      m_last   = m_result;
      void'(mq.pop_front());
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    if (push) mq.push_back('{a: a, b: b, op: op, fwd: fwd});
    accepted = push;
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle(input int n, input logic ordy);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, ordy, acc);
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic fwd, input logic ordy);
    bit acc;
    cycle(1'b1, a, b, op, fwd, ordy, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_opcode = '0;
    in_fwd    = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.in_ready_one", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Single SUB: result two edges after acceptance
    push_op(32'd10, 32'd3, 3'b001, 1'b0, 1'b1);
    check("r020.valid_edge1", 32'(out_valid), 32'd0);
    idle(1, 1'b1);
    check("r020.valid_edge2", 32'(out_valid), 32'd1);
    check("r020.result", out_result, 32'd7);
    check("r020.err", 32'(out_err), 32'd0);
    idle(2, 1'b1);

    // GT then LT back-to-back: results 0 then 1 on consecutive cycles
    push_op(32'd1, 32'd2, 3'b010, 1'b0, 1'b1);
    push_op(32'd1, 32'd2, 3'b011, 1'b0, 1'b1);
    check("r022.first_valid", 32'(out_valid), 32'd1);
    check("r022.first", out_result, 32'd0);
    idle(1, 1'b1);
    check("r022.second_valid", 32'(out_valid), 32'd1);
    check("r022.second", out_result, 32'd1);
    idle(2, 1'b1);

    // Illegal opcode
    push_op(32'd5, 32'd3, 3'b111, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("r023.result", out_result, 32'd0);
    check("r023.err", 32'(out_err), 32'd1);
    check("r023.opcode", 32'(out_opcode), 32'd7);
    idle(2, 1'b1);

    // Forwarding: second op uses the previous result as A when enabled
    push_op(32'd9, 32'd4, 3'b001, 1'b0, 1'b1);
    push_op(32'd77, 32'd2, 3'b001, 1'b1, 1'b1);
    check("r024.first", out_result, 32'd5);
    idle(1, 1'b1);
    check("r024.second", out_result, FWD_ON ? 32'd3 : 32'd75);
    idle(2, 1'b1);

    // Back-pressure: fill the queue with out_ready low, hold a sixth op
    for (int i = 0; i < 5; i++) push_op(32'(100 + i), 32'(i), 3'b001, 1'b0, 1'b0);
    check("r021.occ_full", 32'(occupancy), 32'd4);
    check("r021.in_ready_low", 32'(in_ready), 32'd0);
    check("r021.head_result", out_result, 32'd100);
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++)
      cycle(1'b1, 32'd200, 32'd50, 3'b001, 1'b0, (k >= 2), acc);
    check("r021.held_op_accepted", 32'(acc), 32'd1);
    idle(8, 1'b1);
    check("r021.last_result", out_result, 32'd150);

    // Reset mid-operation with ops queued and a result held
    for (int i = 0; i < 4; i++) push_op(32'(20 + i), 32'd1, 3'b001, 1'b0, 1'b0);
    check("r025.pre_valid", 32'(out_valid), 32'd1);
    check("r025.pre_occ", 32'(occupancy), 32'd3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("r025.async");
    check("r025.alu_a", alu_a, 32'd0);
    @(posedge clk);
    #1;
    check_outputs("r025.held");
    rst_n = 1'b1;
    idle(4, 1'b1);
    check("r025.no_stale", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      cycle(($urandom_range(0, 3) != 0), a, b, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), acc);
    end
    idle(8, 1'b1);
    check("drain.empty", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
